// File: rtl/subtractor_serial_16b.sv
// Bit-serial 16-bit subtractor (diff = in0 - in1 - bin), LSB first, 16 cycles per operation.
// Define SUBTRACTOR_SERIAL_OVF_EN to build signed-overflow detection; otherwise ovf is tied low.
module subtractor_serial_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        bin,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic        br_q, br_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        d_bit;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          a_d     = in0;
          b_d     = in1;
          br_d    = bin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        br_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        a_d   = {1'b0, a_q[15:1]};
        b_d   = {1'b0, b_q[15:1]};
        res_d = {d_bit, res_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_rdy  = (state_q == IDLE);
  assign out_val = (state_q == DONE);
  assign diff    = res_q;
  assign bout    = br_q;

`ifdef SUBTRACTOR_SERIAL_OVF_EN
  // Operand registers are shifted away during CALC, so the signs are kept separately.
  logic sa_q, sa_d;
  logic sb_q, sb_d;

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (state_q == IDLE && in_val) begin
      sa_d = in0[15];
      sb_d = in1[15];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  assign ovf = (state_q == DONE) && (sa_q != sb_q) && (res_q[15] != sa_q);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_serial_16b.sv
// Scoreboard bench for subtractor_serial_16b: driver pushes expected results, monitor pops on output.
module tb_subtractor_serial_16b;

  logic        clk = 1'b0;
  logic        rst_n, in_val, in_rdy, bin, out_val, bout, ovf;
  logic        out_rdy = 1'b0;
  logic [15:0] in0, in1, diff;

  always #5 clk = ~clk;

  subtractor_serial_16b dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
    .in0(in0), .in1(in1), .bin(bin), .out_val(out_val), .out_rdy(out_rdy),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   bp_mode = 1'b0;
  bit   prev_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic c);
    exp_t        e;
    int unsigned ua, ub, uc, full;
    ua     = a;
    ub     = b;
    uc     = c;
    full   = (ua + 32'h10000) - ub - uc;
    e.d    = full[15:0];
    e.bo   = (ua < ub + uc);
`ifdef SUBTRACTOR_SERIAL_OVF_EN
    e.ov   = (a[15] != b[15]) && (e.d[15] != a[15]);
`else
    e.ov   = 1'b0;
`endif
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b, logic c);
    exp_t e;
    int   w = 0;
    in_val = 1'b1;
    in0    = a;
    in1    = b;
    bin    = c;
    while (!in_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_rdy got 0 expected 1 after %0d cycles", w);
      in_val = 1'b0;
      return;
    end
    e     = model(a, b, c);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_val = 1'b0;
    in0    = 16'($urandom);
    in1    = 16'($urandom);
    bin    = 1'($urandom);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sbq.size() != 0 || !in_rdy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0 || !in_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: pending %0d expected 0", sbq.size());
    end
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners [4];
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h8000;
    corners[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  // out_rdy backpressure generator, disabled while directed tests own out_rdy
  initial forever begin
    @(negedge clk);
    if (!bp_mode) out_rdy = ($urandom_range(0, 3) != 0);
  end

  // monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_val = 1'b0;
    end else begin
      if (out_val) begin
        chk("rdy_val_excl", in_rdy, 0);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: diff %0h with nothing outstanding", diff);
        end else begin
          e = sbq[0];
          if (!prev_val) chk("latency", cyc, e.acc + 16);
          chk("diff", diff, e.d);
          chk("bout", bout, e.bo);
          chk("ovf", ovf, e.ov);
          if (out_rdy) void'(sbq.pop_front());
        end
      end
      prev_val = out_val;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n  = 1'b0;
    in_val = 1'b0;
    in0    = '0;
    in1    = '0;
    bin    = 1'b0;
    bp_mode = 1'b1;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_val", out_val, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h0005, 16'h0003, 1'b0);
    wait_drain();
    send(16'h0000, 16'h0001, 1'b0);
    wait_drain();
    send(16'h8000, 16'h0001, 1'b0);
    wait_drain();

    // result held under backpressure while new operands wait
    out_rdy = 1'b0;
    send(16'h1234, 16'h1234, 1'b1);
    w = 0;
    while (!out_val && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_reach_done", out_val, 1);
    in_val = 1'b1;
    in0    = 16'hABCD;
    in1    = 16'h0123;
    bin    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_in_rdy", in_rdy, 0);
      chk("bp_out_val", out_val, 1);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("release_in_rdy", in_rdy, 1);
    chk("release_out_val", out_val, 0);
    send(16'hABCD, 16'h0123, 1'b0);
    wait_drain();

    // reset during the 8th CALC cycle aborts the operation
    send(16'hFFFF, 16'h0001, 1'b0);
    repeat (6) @(negedge clk);
    chk("calc_in_rdy", in_rdy, 0);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("abort_in_rdy", in_rdy, 1);
    chk("abort_out_val", out_val, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_ovf", ovf, 0);
    rst_n = 1'b1;
    send(16'h00FF, 16'h000F, 1'b0);
    wait_drain();

    bp_mode = 1'b0;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subtractor_serial_16b.md
SUBTRACTOR_SERIAL_16B -- requirements
Module: subtractor_serial_16b

Interface
REQ-001 Parameters: none; width fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_val  input  1  operands valid.
REQ-005 in_rdy  output  1  block can accept operands.
REQ-006 in0  input  16  minuend, unsigned/two's-complement.
REQ-007 in1  input  16  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_val  output  1  result valid.
REQ-010 out_rdy  input  1  consumer accepts result.
REQ-011 diff  output  16  in0 - in1 - bin, modulo 2^16.
REQ-012 bout  output  1  borrow-out.
REQ-013 ovf  output  1  signed overflow; see Configuration.

Function
REQ-014 FSM SHALL have states IDLE, CALC, DONE; in_rdy=1 only in IDLE, out_val=1 only in DONE.
REQ-015 IDLE: on in_val&&in_rdy at an edge, SHALL latch in0, in1, bin into internal registers, clear bit counter to 0, and go to CALC.
REQ-016 IDLE with in_val=0 SHALL stay in IDLE; in0/in1/bin SHALL be ignored whenever in_rdy=0.
REQ-017 CALC: each cycle SHALL process one bit, LSB first: d=a^b^br; br_next=(~a&b)|(~a&br)|(b&br), with a,b the current LSBs of the operand shift registers and br the borrow register.
REQ-018 CALC: each cycle SHALL shift both operand registers right one bit, shift d into result MSB, increment counter.
REQ-019 CALC SHALL last exactly 16 cycles; on the edge where counter==15, SHALL go to DONE.
REQ-020 Latency: accepted at edge N -> out_val=1 after edge N+16.
REQ-021 DONE: diff SHALL equal full 16-bit result; bout SHALL equal final borrow, i.e. 1 iff in0 < in1+bin unsigned.
REQ-022 DONE: diff, bout, ovf SHALL hold stable while out_rdy=0 (unbounded backpressure).
REQ-023 DONE with out_rdy=1 at an edge SHALL return to IDLE; no combinational in_rdy/out_rdy path; next operand accepted earliest one cycle later.
REQ-024 out_rdy SHALL be ignored outside DONE.
REQ-025 diff/bout/ovf outside DONE are don't-care for consumers but SHALL never be X after reset.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE from any state, aborting any operation in progress (no partial result emitted).
REQ-027 After reset: in_rdy=1, out_val=0, diff=16'h0000, bout=0, ovf=0, counter=0, borrow register=0.
REQ-028 rst_n SHALL take priority over in_val and out_rdy in the same cycle.

Configuration
REQ-029 Macro SUBTRACTOR_SERIAL_OVF_EN: when defined, ovf in DONE SHALL equal (in0[15]!=in1[15]) && (diff[15]!=in0[15]) using latched operand signs.
REQ-030 Without SUBTRACTOR_SERIAL_OVF_EN, ovf SHALL be tied to 0 and no sign-capture logic SHALL be built; port list unchanged.

Verification
REQ-031 Reset, then in0=16'h0005, in1=16'h0003, bin=0 accepted at edge N -> out_val=1 after edge N+16, diff=16'h0002, bout=0.
REQ-032 in0=16'h0000, in1=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0.
REQ-033 With SUBTRACTOR_SERIAL_OVF_EN: in0=16'h8000, in1=16'h0001 -> diff=16'h7FFF, bout=0, ovf=1; without macro, same stimulus -> ovf=0.
REQ-034 in0=in1=16'h1234, bin=1 -> diff=16'hFFFF, bout=1; then hold out_rdy=0 for 5 cycles while driving in_val=1 with new operands -> diff/bout stable, in_rdy=0, new operands not consumed; out_rdy=1 -> IDLE next cycle, new operands accepted the cycle after.
REQ-035 Accept operands, assert rst_n=0 at 8th CALC cycle -> next cycle in_rdy=1, out_val=0, diff=16'h0000; following op 16'h00FF-16'h000F -> diff=16'h00F0 with full 16-cycle latency.
